// File: rtl/blood_pkg.sv
// Shared blood-type encodings, expected probability total and sequencer state set.
package blood_pkg;
   localparam logic [1:0] BT_O  = 2'b00;
   localparam logic [1:0] BT_B  = 2'b01;
   localparam logic [1:0] BT_A  = 2'b10;
   localparam logic [1:0] BT_AB = 2'b11;

   // Calculator counts are sixteenths, so a well-formed distribution sums to 16.
   localparam int EXP_TOTAL = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SWEEP,
      S_CHECK,
      S_OUT,
      S_DONE
   } state_t;
endpackage

// File: rtl/count_to_pct_bcd.sv
// Converts a count in sixteenths to floor(count*25/4) percent as three BCD digits.
module count_to_pct_bcd (
   input  logic [4:0] count,
   output logic [3:0] pct_h,
   output logic [3:0] pct_t,
   output logic [3:0] pct_o
);
   logic [9:0] prod;
   logic [7:0] pct;
   logic [7:0] rem;
   logic [7:0] tq;
   logic [7:0] oq;
   logic       unused_bits;

   // Out-of-range counts (17..31) reach at most 193 %, so hundreds is only 0 or 1.
   always_comb begin
      prod  = {5'd0, count} * 10'd25;
      pct   = prod[9:2];
      pct_h = (pct >= 8'd100) ? 4'd1 : 4'd0;
      rem   = (pct >= 8'd100) ? pct - 8'd100 : pct;
      tq    = rem / 8'd10;
      oq    = rem % 8'd10;
      pct_t = tq[3:0];
      pct_o = oq[3:0];
   end

   assign unused_bits = ^{prod[1:0], tq[7:4], oq[7:4]};
endmodule

// File: rtl/blood_result_sequencer.sv
// Sweeps the external probability calculator over the four child types, checks the
// total, then streams (type, count, percent) results over a valid/ready handshake.
module blood_result_sequencer
   import blood_pkg::*;
#(
   parameter bit SKIP_ZERO = 1'b0,
   parameter int TOTAL     = EXP_TOTAL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] father_in,
   input  logic [1:0] mother_in,
   output logic [1:0] key_out,
   input  logic [4:0] symbol_in,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [1:0] res_key,
   output logic [4:0] res_count,
   output logic [3:0] res_pct_h,
   output logic [3:0] res_pct_t,
   output logic [3:0] res_pct_o,
   output logic       busy,
   output logic       done,
   output logic       sum_err
);
   state_t          state, state_n;
   logic [1:0]      idx;
   logic [1:0]      oidx, oidx_n;
   logic [1:0]      father_q, mother_q;
   logic [3:0][4:0] cnt;
   logic [3:0]      elig;
   logic [6:0]      sum;
   logic [2:0]      base;
   logic            found;
   logic            unused_parents;

   // Parents are held for the duration of a request; the calculator consumes them directly.
   assign unused_parents = ^{father_q, mother_q};

   always_comb begin
      sum = 7'd0;
      for (int i = 0; i < 4; i++) begin
         sum     = sum + {2'b00, cnt[i]};
         elig[i] = !SKIP_ZERO || (cnt[i] != 5'd0);
      end
   end

   // Lowest eligible key at or after base: key 0 when leaving CHECK, else the one after oidx.
   always_comb begin
      base   = (state == S_OUT) ? ({1'b0, oidx} + 3'd1) : 3'd0;
      found  = 1'b0;
      oidx_n = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (elig[i] && (3'(i) >= base)) begin
            found  = 1'b1;
            oidx_n = 2'(i);
         end
      end
   end

   always_comb begin
      state_n   = state;
      busy      = (state != S_IDLE);
      done      = 1'b0;
      res_valid = 1'b0;
      key_out   = BT_O;
      case (state)
         S_IDLE:  if (start) state_n = S_SWEEP;
         S_SWEEP: begin
            key_out = idx;
            if (idx == BT_AB) state_n = S_CHECK;
         end
         S_CHECK: state_n = found ? S_OUT : S_DONE;
         S_OUT: begin
            res_valid = 1'b1;
            if (res_ready && !found) state_n = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         idx      <= 2'd0;
         oidx     <= 2'd0;
         cnt      <= '0;
         father_q <= 2'd0;
         mother_q <= 2'd0;
         sum_err  <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            S_IDLE: if (start) begin
               father_q <= father_in;
               mother_q <= mother_in;
               sum_err  <= 1'b0;
               idx      <= 2'd0;
            end
            S_SWEEP: begin
               cnt[idx] <= symbol_in;
               idx      <= idx + 2'd1;
            end
            S_CHECK: begin
               sum_err <= (sum != 7'(TOTAL));
               oidx    <= oidx_n;
            end
            S_OUT: if (res_ready && found) oidx <= oidx_n;
            default: ;
         endcase
      end
   end

   // Result data is a pure function of oidx and the captured counts, so it holds under stall.
   assign res_key   = oidx;
   assign res_count = cnt[oidx];

   count_to_pct_bcd u_pct (
      .count (cnt[oidx]),
      .pct_h (res_pct_h),
      .pct_t (res_pct_t),
      .pct_o (res_pct_o)
   );
endmodule

// File: tb/tb_blood_result_sequencer.sv
// Scoreboard bench: two instances (SKIP_ZERO 0 and 1) driven by a table-based calculator.
module tb_blood_result_sequencer;
   import blood_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start;
   logic        rdy [2];
   logic [1:0]  father, mother;
   logic [4:0]  tab [4];
   logic [1:0]  key_out [2];
   logic [1:0]  res_key [2];
   logic [4:0]  sym [2];
   logic [4:0]  res_count [2];
   logic [3:0]  ph [2];
   logic [3:0]  pt [2];
   logic [3:0]  po [2];
   logic        res_valid [2];
   logic        busy [2];
   logic        done [2];
   logic        sum_err [2];
   logic [18:0] q0 [$];
   logic [18:0] q1 [$];
   logic [18:0] held [2];
   bit          hold_pend [2] = '{1'b0, 1'b0};
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   assign sym[0] = tab[key_out[0]];
   assign sym[1] = tab[key_out[1]];

   blood_result_sequencer #(.SKIP_ZERO(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .father_in(father), .mother_in(mother),
      .key_out(key_out[0]), .symbol_in(sym[0]), .res_valid(res_valid[0]), .res_ready(rdy[0]),
      .res_key(res_key[0]), .res_count(res_count[0]), .res_pct_h(ph[0]), .res_pct_t(pt[0]),
      .res_pct_o(po[0]), .busy(busy[0]), .done(done[0]), .sum_err(sum_err[0]));

   blood_result_sequencer #(.SKIP_ZERO(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .father_in(father), .mother_in(mother),
      .key_out(key_out[1]), .symbol_in(sym[1]), .res_valid(res_valid[1]), .res_ready(rdy[1]),
      .res_key(res_key[1]), .res_count(res_count[1]), .res_pct_h(ph[1]), .res_pct_t(pt[1]),
      .res_pct_o(po[1]), .busy(busy[1]), .done(done[1]), .sum_err(sum_err[1]));

   // Monitor: stall stability and in-order scoreboard compare on every accepted result.
   always @(negedge clk) begin
      logic [18:0] act, expv;
      bit          have;
      for (int i = 0; i < 2; i++) begin
         act = {res_key[i], res_count[i], ph[i], pt[i], po[i]};
         if (hold_pend[i]) begin
            n_cmp++;
            if (!res_valid[i] || act != held[i]) begin
               n_err++;
               $display("FAIL hold%0d: got valid=%0b data=%h, required valid=1 data=%h",
                        i, res_valid[i], act, held[i]);
            end
         end
         hold_pend[i] = res_valid[i] && !rdy[i] && !rst;
         held[i]      = act;
         if (res_valid[i] && rdy[i] && !rst) begin
            n_cmp++;
            have = 1'b0;
            expv = '0;
            if (i == 0 && q0.size() != 0) begin expv = q0.pop_front(); have = 1'b1; end
            if (i == 1 && q1.size() != 0) begin expv = q1.pop_front(); have = 1'b1; end
            if (!have) begin
               n_err++;
               $display("FAIL result%0d: got unexpected key=%0d cnt=%0d, required no result",
                        i, act[18:17], act[16:12]);
            end else if (act != expv) begin
               n_err++;
               $display("FAIL result%0d: got key=%0d cnt=%0d pct=%0d%0d%0d, required key=%0d cnt=%0d pct=%0d%0d%0d",
                        i, act[18:17], act[16:12], act[11:8], act[7:4], act[3:0],
                        expv[18:17], expv[16:12], expv[11:8], expv[7:4], expv[3:0]);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   // i: 0 -> instance 0 only, 1 -> instance 1 only, 2 -> both.
   task automatic px(input int i, input int k, input int c, input int h, input int t, input int o);
      if (i != 1) q0.push_back({2'(k), 5'(c), 4'(h), 4'(t), 4'(o)});
      if (i != 0) q1.push_back({2'(k), 5'(c), 4'(h), 4'(t), 4'(o)});
   endtask

   task automatic run(input string nm, input int f, input int m,
                      input int c0, input int c1, input int c2, input int c3,
                      input int err, input int lat0, input int lat1,
                      input int stall, input int sid);
      int c, d0, d1, fv;
      tab[0] = 5'(c0); tab[1] = 5'(c1); tab[2] = 5'(c2); tab[3] = 5'(c3);
      father = 2'(f);
      mother = 2'(m);
      start  = 1'b1;
      tick;
      start  = 1'b0;
      c = 0; d0 = -1; d1 = -1; fv = -1;
      while ((d0 < 0 || d1 < 0) && c < 60) begin
         tick;
         c++;
         if (fv < 0 && res_valid[0]) fv = c;
         if (d0 < 0 && done[0]) d0 = c;
         if (d1 < 0 && done[1]) d1 = c;
         if (stall != 0 && c == 6) rdy[0] = 1'b0;
         if (stall != 0 && c == 9) rdy[0] = 1'b1;
      end
      chk({nm, "_first_valid"}, fv, 5);
      chk({nm, "_done_lat0"}, d0, lat0);
      chk({nm, "_done_lat1"}, d1, lat1);
      chk({nm, "_sum_err0"}, int'(sum_err[0]), err);
      chk({nm, "_sum_err1"}, int'(sum_err[1]), err);
      if (sid != 0) begin
         start = 1'b1;
         tick;
         start = 1'b0;
         chk({nm, "_start_in_done0"}, int'(busy[0]), 0);
         chk({nm, "_start_in_done1"}, int'(busy[1]), 0);
      end else begin
         tick;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; father = BT_O; mother = BT_O;
      rdy[0] = 1'b1; rdy[1] = 1'b1;
      for (int k = 0; k < 4; k++) tab[k] = 5'd0;
      tick;
      tick;
      for (int i = 0; i < 2; i++)
         chk($sformatf("reset_state%0d", i),
             int'({busy[i], done[i], res_valid[i], sum_err[i], key_out[i], res_key[i],
                   res_count[i], ph[i], pt[i], po[i]}), 0);
      rst = 1'b0;
      tick;

      // A x B: O 1/16, B 3/16, A 3/16, AB 9/16; start during DONE is ignored.
      px(2, 0, 1, 0, 0, 6); px(2, 1, 3, 0, 1, 8); px(2, 2, 3, 0, 1, 8); px(2, 3, 9, 0, 5, 6);
      run("AxB", BT_A, BT_B, 1, 3, 3, 9, 0, 9, 9, 0, 1);

      // AB x AB: zero O count dropped by the skipping instance.
      px(0, 0, 0, 0, 0, 0); px(2, 1, 4, 0, 2, 5); px(2, 2, 4, 0, 2, 5); px(2, 3, 8, 0, 5, 0);
      run("ABxAB", BT_AB, BT_AB, 0, 4, 4, 8, 0, 9, 8, 0, 0);

      // O x O: single 100 % result on the skipping instance.
      px(2, 0, 16, 1, 0, 0); px(0, 1, 0, 0, 0, 0); px(0, 2, 0, 0, 0, 0); px(0, 3, 0, 0, 0, 0);
      run("OxO", BT_O, BT_O, 16, 0, 0, 0, 0, 9, 6, 0, 0);

      // Calculator stuck at 5: sum 20 flags sum_err, results still emitted.
      for (int k = 0; k < 4; k++) px(2, k, 5, 0, 3, 1);
      run("force5", BT_A, BT_A, 5, 5, 5, 5, 1, 9, 9, 0, 0);

      // Ready low for 3 cycles on the second result of instance 0; start clears sum_err.
      px(0, 0, 0, 0, 0, 0); px(2, 1, 4, 0, 2, 5); px(2, 2, 4, 0, 2, 5); px(2, 3, 8, 0, 5, 0);
      run("stall", BT_AB, BT_AB, 0, 4, 4, 8, 0, 12, 8, 1, 0);

      // Counts above 16 are kept raw: 17 -> 106 %, 31 -> 193 %.
      px(2, 0, 17, 1, 0, 6); px(0, 1, 0, 0, 0, 0); px(0, 2, 0, 0, 0, 0); px(2, 3, 31, 1, 9, 3);
      run("over16", BT_B, BT_A, 17, 0, 0, 31, 1, 9, 7, 0, 0);

      // All-zero counts: skipping instance goes straight from CHECK to DONE.
      for (int k = 0; k < 4; k++) px(0, k, 0, 0, 0, 0);
      run("allzero", BT_O, BT_AB, 0, 0, 0, 0, 1, 9, 5, 0, 0);

      // Busy-time start ignored, then reset mid-sweep at index 2.
      tab[0] = 5'd1; tab[1] = 5'd3; tab[2] = 5'd3; tab[3] = 5'd9;
      father = BT_A; mother = BT_B;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("busy_start_key0", int'(key_out[0]), 2);
      chk("busy_start_key1", int'(key_out[1]), 2);
      rst = 1'b1;
      tick;
      for (int i = 0; i < 2; i++)
         chk($sformatf("mid_sweep_reset%0d", i),
             int'({busy[i], done[i], res_valid[i], sum_err[i], key_out[i], res_key[i],
                   res_count[i], ph[i], pt[i], po[i]}), 0);
      rst = 1'b0;
      tick;
      tick;
      tick;
      chk("idle_after_rst0", int'(busy[0]), 0);
      chk("idle_after_rst1", int'(busy[1]), 0);

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
